// File: rtl/alignment_supervisor.sv
// alignment_supervisor: supervises a deserializer word aligner. Issues realign
// requests, waits for alignment, counts settling words, and reports
// LOCKED or FAIL. Every output is a flop loaded from the next-state decode.
// Optional feature macro: ALIGN_AUTO_RELOCK_EN. When it is defined, a lock
// loss in LOCKED restarts alignment automatically and is counted in
// relock_count. When it is undefined, a lock loss goes to FAIL and
// relock_count is tied to 0.
module alignment_supervisor #(
  parameter int RETRY_MAX    = 4,
  parameter int SETTLE_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sw_realign,
  input  logic [15:0] timeout,
  input  logic        alignment_found,
  input  logic        block_update,
  output logic        realign,
  output logic        shortsearch,
  output logic        locked,
  output logic        data_gate,
  output logic        fail,
  output logic [2:0]  state,
  output logic [2:0]  retry_count,
  output logic [7:0]  relock_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_e;

  localparam int              WORD_W     = $clog2(SETTLE_WORDS + 1);
  localparam logic [2:0]      RETRY_LAST = 3'(RETRY_MAX - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(SETTLE_WORDS - 1);

  state_e            state_q, state_d;
  logic [2:0]        retry_q, retry_d;
  logic [15:0]       timer_q, timer_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              realign_q, realign_d;
  logic              shortsearch_q, shortsearch_d;
  logic              locked_q, locked_d;
  logic              data_gate_q, data_gate_d;
  logic              fail_q, fail_d;
  logic              give_up;
  logic              lock_loss;
  logic              state_active;

`ifdef ALIGN_AUTO_RELOCK_EN
  logic [7:0]        relock_q, relock_d;
`endif

  // Next-state, counter, and registered-output decode for the supervisor.
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    timer_d      = timer_q;
    word_d       = word_q;
    give_up      = 1'b0;
    lock_loss    = 1'b0;
    state_active = (state_q inside {ST_REQ, ST_WAIT, ST_SETTLE, ST_LOCKED, ST_FAIL});
`ifdef ALIGN_AUTO_RELOCK_EN
    relock_d     = relock_q;
`endif

    if (!enable) begin
      state_d = ST_IDLE;
      retry_d = '0;
      timer_d = '0;
      word_d  = '0;
    end else if (sw_realign && state_active) begin
      state_d = ST_REQ;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
          retry_d = '0;
        end
        ST_REQ: begin
          timer_d = (timeout == 16'd0) ? 16'd1 : timeout;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (alignment_found) begin
            state_d = ST_SETTLE;
            word_d  = '0;
          end else if (timer_q <= 16'd1) begin
            give_up = 1'b1;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        ST_SETTLE: begin
          if (!alignment_found) begin
            give_up = 1'b1;
          end else if (block_update) begin
            if (word_q == WORD_LAST) begin
              state_d = ST_LOCKED;
              retry_d = '0;
            end else begin
              word_d = word_q + WORD_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          lock_loss = !alignment_found;
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      endcase

      if (give_up) begin
        if (retry_q == RETRY_LAST) begin
          state_d = ST_FAIL;
        end else begin
          retry_d = retry_q + 3'd1;
          state_d = ST_REQ;
        end
      end

      if (lock_loss) begin
`ifdef ALIGN_AUTO_RELOCK_EN
        state_d  = ST_REQ;
        retry_d  = '0;
        relock_d = (relock_q == 8'd255) ? 8'd255 : relock_q + 8'd1;
`else
        state_d  = ST_FAIL;
`endif
      end
    end

    realign_d     = (state_d == ST_REQ);
    shortsearch_d = (state_d != ST_IDLE) && (retry_d == 3'd0);
    locked_d      = (state_d == ST_LOCKED);
    data_gate_d   = (state_d == ST_LOCKED);
    fail_d        = (state_d == ST_FAIL);
  end

  // State, counters and output flops; reset clears everything at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      retry_q       <= '0;
      timer_q       <= '0;
      word_q        <= '0;
      realign_q     <= 1'b0;
      shortsearch_q <= 1'b0;
      locked_q      <= 1'b0;
      data_gate_q   <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      retry_q       <= retry_d;
      timer_q       <= timer_d;
      word_q        <= word_d;
      realign_q     <= realign_d;
      shortsearch_q <= shortsearch_d;
      locked_q      <= locked_d;
      data_gate_q   <= data_gate_d;
      fail_q        <= fail_d;
    end
  end

`ifdef ALIGN_AUTO_RELOCK_EN
  // Saturating count of automatically recovered lock losses; only reset clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      relock_q <= '0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign relock_count = relock_q;
`else
  assign relock_count = 8'd0;
`endif

  assign realign     = realign_q;
  assign shortsearch = shortsearch_q;
  assign locked      = locked_q;
  assign data_gate   = data_gate_q;
  assign fail        = fail_q;
  assign state       = state_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_alignment_supervisor.sv
// Scoreboard bench for alignment_supervisor. The stimulus process drives one
// cycle at a time. It advances a behavioural model that works in absolute
// cycle deadlines, and it queues the output vector expected after the next
// clock edge. A separate monitor pops each entry one time unit after every
// rising edge and compares it against the DUT.
module tb_alignment_supervisor;

  localparam int RETRY_MAX    = 4;
  localparam int SETTLE_WORDS = 64;

  localparam int S_IDLE   = 0;
  localparam int S_REQ    = 1;
  localparam int S_WAIT   = 2;
  localparam int S_SETTLE = 3;
  localparam int S_LOCKED = 4;
  localparam int S_FAIL   = 5;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        sw_realign = 1'b0;
  logic [15:0] timeout = 16'd0;
  logic        alignment_found = 1'b0;
  logic        block_update = 1'b0;
  logic        realign, shortsearch, locked, data_gate, fail;
  logic [2:0]  state, retry_count;
  logic [7:0]  relock_count;

  int tests_run = 0;
  int tests_failed = 0;
  string cur_phase = "init";
  logic [18:0] exp_q[$];

  // Reference model state: attempt count, absolute expiry cycle, and words seen.
  int m_state = S_IDLE;
  int m_retry = 0;
  int m_relock = 0;
  int m_words = 0;
  int m_deadline = 0;
  int m_cycle = 0;

  alignment_supervisor #(.RETRY_MAX(RETRY_MAX), .SETTLE_WORDS(SETTLE_WORDS)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .sw_realign(sw_realign),
    .timeout(timeout),
    .alignment_found(alignment_found),
    .block_update(block_update),
    .realign(realign),
    .shortsearch(shortsearch),
    .locked(locked),
    .data_gate(data_gate),
    .fail(fail),
    .state(state),
    .retry_count(retry_count),
    .relock_count(relock_count)
  );

  always #5 clock = ~clock;

  function automatic logic [18:0] actualNow();
    return {realign, shortsearch, locked, data_gate, fail, state, retry_count, relock_count};
  endfunction

  function automatic logic [18:0] expectedNow();
    logic rl, ss, lk, fl;
    rl = (m_state == S_REQ);
    ss = (m_state != S_IDLE) && (m_retry == 0);
    lk = (m_state == S_LOCKED);
    fl = (m_state == S_FAIL);
    return {rl, ss, lk, lk, fl, 3'(m_state), 3'(m_retry), 8'(m_relock)};
  endfunction

  task automatic checkOutput(input string name, input logic [18:0] act, input logic [18:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s @%0t: actual rl=%0b ss=%0b lk=%0b dg=%0b fl=%0b st=%0d rt=%0d rc=%0d required rl=%0b ss=%0b lk=%0b dg=%0b fl=%0b st=%0d rt=%0d rc=%0d",
               name, $time, act[18], act[17], act[16], act[15], act[14], act[13:11], act[10:8], act[7:0],
               exp[18], exp[17], exp[16], exp[15], exp[14], exp[13:11], exp[10:8], exp[7:0]);
    end
  endtask

  // A failed attempt: another try while attempts remain, otherwise FAIL.
  task automatic modelGiveUp();
    if (m_retry == RETRY_MAX - 1) begin
      m_state = S_FAIL;
    end else begin
      m_retry = m_retry + 1;
      m_state = S_REQ;
    end
  endtask

  task automatic modelStep(input bit rst, input bit en, input bit sw, input logic [15:0] to,
                           input bit fnd, input bit bu);
    if (rst) begin
      m_state = S_IDLE;
      m_retry = 0;
      m_relock = 0;
      m_words = 0;
    end else if (!en) begin
      m_state = S_IDLE;
      m_retry = 0;
    end else if (sw && m_state != S_IDLE) begin
      m_state = S_REQ;
      m_retry = 0;
    end else begin
      case (m_state)
        S_IDLE: begin
          m_state = S_REQ;
          m_retry = 0;
        end
        S_REQ: begin
          m_deadline = m_cycle + ((to == 16'd0) ? 1 : int'(to));
          m_state = S_WAIT;
        end
        S_WAIT: begin
          if (fnd) begin
            m_state = S_SETTLE;
            m_words = 0;
          end else if (m_cycle == m_deadline) begin
            modelGiveUp();
          end
        end
        S_SETTLE: begin
          if (!fnd) begin
            modelGiveUp();
          end else if (bu) begin
            m_words = m_words + 1;
            if (m_words == SETTLE_WORDS) begin
              m_state = S_LOCKED;
              m_retry = 0;
            end
          end
        end
        S_LOCKED: begin
          if (!fnd) begin
`ifdef ALIGN_AUTO_RELOCK_EN
            m_relock = (m_relock < 255) ? m_relock + 1 : 255;
            m_retry = 0;
            m_state = S_REQ;
`else
            m_state = S_FAIL;
`endif
          end
        end
        default: begin
        end
      endcase
    end
    m_cycle = m_cycle + 1;
  endtask

  // Drive one cycle of inputs from a falling edge and queue the post-edge expectation.
  task automatic applyStimulus(input bit rn, input bit en, input bit sw, input logic [15:0] to,
                               input bit fnd, input bit bu);
    reset_n = rn;
    enable = en;
    sw_realign = sw;
    timeout = to;
    alignment_found = fnd;
    block_update = bu;
    modelStep(!rn, en, sw, to, fnd, bu);
    exp_q.push_back(expectedNow());
    @(negedge clock);
  endtask

  task automatic driveToLock(input logic [15:0] to);
    int n;
    n = 0;
    if (m_state == S_FAIL) applyStimulus(1, 1, 1, to, 1, 1);
    while (m_state != S_LOCKED && n < 500) begin
      applyStimulus(1, 1, 0, to, 1, 1);
      n++;
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation after every edge.
  initial begin
    logic [18:0] exp_v;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        checkOutput(cur_phase, actualNow(), exp_v);
      end
    end
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #2000000;
    tests_failed++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    int n;
    bit fnd;
    @(negedge clock);

    cur_phase = "reset";
    repeat (3) applyStimulus(0, 0, 0, 16'd0, 0, 0);

    // Find alignment 40 cycles after realign, then settle with 64 words.
    cur_phase = "first_lock";
    applyStimulus(1, 1, 0, 16'd100, 0, 0);
    for (int j = 0; j < 40; j++) applyStimulus(1, 1, 0, 16'd100, 0, 0);
    n = 0;
    while (m_state != S_LOCKED && n < 1000) begin
      applyStimulus(1, 1, 0, 16'd100, 1, 1'($urandom_range(0, 1)));
      n++;
    end
    repeat (4) applyStimulus(1, 1, 0, 16'd100, 1, 1);

    // Exhaust every attempt with alignment never found.
    cur_phase = "retry_fail";
    applyStimulus(1, 0, 0, 16'd10, 0, 0);
    repeat (60) applyStimulus(1, 1, 0, 16'd10, 0, 0);

    // A software realign that coincides with timer expiry, with and without enable.
    cur_phase = "sw_vs_timeout";
    applyStimulus(1, 1, 1, 16'd5, 0, 0);
    n = 0;
    while (!(m_state == S_WAIT && m_cycle == m_deadline && m_retry == 1) && n < 60) begin
      applyStimulus(1, 1, 0, 16'd5, 0, 0);
      n++;
    end
    applyStimulus(1, 1, 1, 16'd5, 0, 0);
    n = 0;
    while (!(m_state == S_WAIT && m_cycle == m_deadline && m_retry == 1) && n < 60) begin
      applyStimulus(1, 1, 0, 16'd5, 0, 0);
      n++;
    end
    applyStimulus(1, 0, 1, 16'd5, 0, 0);
    repeat (2) applyStimulus(1, 1, 0, 16'd0, 0, 0);

    // One-cycle lock loss while LOCKED.
    cur_phase = "lock_loss";
    driveToLock(16'd20);
    repeat (3) applyStimulus(1, 1, 0, 16'd20, 1, 1);
    applyStimulus(1, 1, 0, 16'd20, 0, 1);
    repeat (4) applyStimulus(1, 1, 0, 16'd20, 1, 0);

    // Asynchronous reset pulse in the middle of SETTLE.
    cur_phase = "reset_mid_settle";
    if (m_state == S_FAIL) applyStimulus(1, 1, 1, 16'd20, 1, 1);
    n = 0;
    while (!(m_state == S_SETTLE && m_words > 5) && n < 100) begin
      applyStimulus(1, 1, 0, 16'd20, 1, 1);
      n++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", actualNow(), 19'd0);
    @(negedge clock);
    repeat (2) applyStimulus(0, 1, 0, 16'd7, 1, 1);
    driveToLock(16'd7);

    // Randomized traffic: a choppy phase, then a phase with more stable alignment.
    cur_phase = "random";
    fnd = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, (i < 1500) ? 19 : 199) == 0) fnd = !fnd;
      applyStimulus(($urandom_range(0, 999) != 0),
                    ($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 149) == 0),
                    16'($urandom_range(0, 12)),
                    fnd,
                    ($urandom_range(0, 3) != 0));
    end

    // Repeated lock losses drive relock_count toward and past its ceiling.
    cur_phase = "relock_saturate";
    driveToLock(16'd3);
`ifdef ALIGN_AUTO_RELOCK_EN
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1, 1, 0, 16'd3, 0, 1);
      driveToLock(16'd3);
    end
`else
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 16'd3, 0, 1);
      repeat (2) applyStimulus(1, 1, 0, 16'd3, 1, 1);
      driveToLock(16'd3);
    end
`endif
    repeat (3) applyStimulus(1, 1, 0, 16'd3, 1, 1);

    // Let the monitor drain the queue, then report.
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() > 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
